// File: rtl/w4823_fir_pkg.sv
// rtl/w4823_fir_pkg.sv - shared types, width helpers and output rounding for the multi-channel FIR
package w4823_fir_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  typedef struct packed {
    logic         sat;
    logic [127:0] val;
  } rs_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic int chw(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Round half up by the given shift, then clip into a signed dw-bit range.
  function automatic rs_t round_sat(input logic signed [127:0] acc, input int shift, input int dw);
    logic signed [127:0] r;
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    rs_t                 o;
    r = acc;
    if (shift > 0) r = (acc + (128'sd1 <<< (shift - 1))) >>> shift;
    hi = (128'sd1 <<< (dw - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (dw - 1));
    o.sat = 1'b0;
    o.val = r;
    if (r > hi) begin
      o.sat = 1'b1;
      o.val = hi;
    end else if (r < lo) begin
      o.sat = 1'b1;
      o.val = lo;
    end
    return o;
  endfunction

endpackage

// File: rtl/w4823_fir_ram.sv
// rtl/w4823_fir_ram.sv - synchronous 1W1R RAM with registered read, no reset
module w4823_fir_ram
  import w4823_fir_pkg::*;
#(
  parameter int W = 16,
  parameter int D = 64,
  localparam int A = clog2(D)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [A-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [A-1:0] raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [D];
  logic [W-1:0] rdata_q;
  logic [W-1:0] rdata_d;

  always_comb rdata_d = mem[raddr];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/w4823_fir_mc.sv
// rtl/w4823_fir_mc.sv - time-multiplexed serial-MAC FIR, per-channel rings, double-banked coefficients
module w4823_fir_mc
  import w4823_fir_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CW    = 17,
  parameter int NTAP  = 64,
  parameter int NCH   = 2,
  parameter int SHIFT = 15,
  localparam int AW   = clog2(NTAP),
  localparam int CHW  = chw(NCH),
  localparam int ACCW = DW + CW + AW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  din,
  input  logic [CHW-1:0] din_ch,
  input  logic           valid_in,
  output logic           ready,
  input  logic [CW-1:0]  cin,
  input  logic [AW-1:0]  caddr,
  input  logic           cload,
  input  logic           cswap,
  output logic [DW-1:0]  dout,
  output logic [CHW-1:0] dout_ch,
  output logic           valid,
  output logic           sat,
  output logic           err
);

  localparam logic [AW:0]   FILL_MAX = (AW + 1)'(NTAP);
  localparam logic [AW-1:0] LAST_TAP = AW'(NTAP - 1);

  state_t state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] wptr_q [NCH];
  logic [AW-1:0] wptr_d [NCH];
  logic [AW:0]   fill_q [NCH];
  logic [AW:0]   fill_d [NCH];
  logic [AW-1:0] base_q, base_d;
  logic [AW:0]   nfill_q, nfill_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic bank_q, bank_d, pend_q, pend_d;
  logic en1_q, en1_d;
  logic signed [DW+CW-1:0] prod_q, prod_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic [DW-1:0]  dout_q, dout_d;
  logic [CHW-1:0] dout_ch_q, dout_ch_d;
  logic valid_q, valid_d, sat_q, sat_d, err_q, err_d;

  logic legal, accept, issue, ld_out;
  logic [DW-1:0] x_raw;
  logic [CW-1:0] c_raw;
  logic signed [DW-1:0] x_rd;
  logic signed [CW-1:0] c_rd;
  rs_t  rs;
  logic unused_rs;

  assign legal  = int'(din_ch) < NCH;
  assign accept = ready & valid_in & legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_MAC;
      S_MAC:   if (k_q == LAST_TAP) state_d = S_DRAIN;
      S_DRAIN: if (k_q == AW'(1)) state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready  = (state_q == S_IDLE);
    issue  = (state_q == S_MAC);
    ld_out = (state_q == S_DRAIN) && (k_q == AW'(1));
  end

  // One counter serves as the tap index in MAC and as the drain timer.
  always_comb begin
    k_d = '0;
    if (state_q == S_MAC)   k_d = (k_q == LAST_TAP) ? '0 : k_q + AW'(1);
    if (state_q == S_DRAIN) k_d = k_q + AW'(1);
  end

  always_comb begin
    wptr_d  = wptr_q;
    fill_d  = fill_q;
    base_d  = base_q;
    nfill_d = nfill_q;
    ch_d    = ch_q;
    bank_d  = bank_q;
    pend_d  = pend_q | cswap;
    if (accept) begin
      wptr_d[din_ch] = wptr_q[din_ch] + AW'(1);
      fill_d[din_ch] = (fill_q[din_ch] == FILL_MAX) ? FILL_MAX : fill_q[din_ch] + (AW + 1)'(1);
      base_d  = wptr_q[din_ch];
      nfill_d = fill_d[din_ch];
      ch_d    = din_ch;
      if (pend_q | cswap) bank_d = ~bank_q;
      pend_d = 1'b0;
    end
  end

  assign x_rd = x_raw;
  assign c_rd = c_raw;

  // Taps beyond the channel's fill level are masked so stale ring contents never leak in.
  always_comb begin
    en1_d  = issue && ({1'b0, k_q} < nfill_q);
    prod_d = en1_q ? (DW + CW)'(x_rd) * (DW + CW)'(c_rd) : '0;
    acc_d  = accept ? '0 : acc_q + ACCW'(prod_q);
  end

  assign rs        = round_sat(128'(acc_d), SHIFT, DW);
  assign unused_rs = ^rs.val[127:DW];

  always_comb begin
    dout_d    = dout_q;
    dout_ch_d = dout_ch_q;
    sat_d     = sat_q;
    if (ld_out) begin
      dout_d    = rs.val[DW-1:0];
      dout_ch_d = ch_q;
      sat_d     = rs.sat;
    end
    valid_d = ld_out;
    err_d   = ready & valid_in & ~legal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q       <= '0;
      for (int i = 0; i < NCH; i++) begin
        wptr_q[i] <= '0;
        fill_q[i] <= '0;
      end
      base_q    <= '0;
      nfill_q   <= '0;
      ch_q      <= '0;
      bank_q    <= 1'b0;
      pend_q    <= 1'b0;
      en1_q     <= 1'b0;
      prod_q    <= '0;
      acc_q     <= '0;
      dout_q    <= '0;
      dout_ch_q <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      k_q       <= k_d;
      wptr_q    <= wptr_d;
      fill_q    <= fill_d;
      base_q    <= base_d;
      nfill_q   <= nfill_d;
      ch_q      <= ch_d;
      bank_q    <= bank_d;
      pend_q    <= pend_d;
      en1_q     <= en1_d;
      prod_q    <= prod_d;
      acc_q     <= acc_d;
      dout_q    <= dout_d;
      dout_ch_q <= dout_ch_d;
      valid_q   <= valid_d;
      sat_q     <= sat_d;
      err_q     <= err_d;
    end
  end

  w4823_fir_ram #(.W(DW), .D((1 << CHW) * NTAP)) u_dline (
    .clk   (clk),
    .we    (accept),
    .waddr ({din_ch, wptr_q[din_ch]}),
    .wdata (din),
    .raddr ({ch_q, base_q - k_q}),
    .rdata (x_raw)
  );

  // Bank select is the address MSB; loads always land in the inactive bank.
  w4823_fir_ram #(.W(CW), .D(2 * NTAP)) u_coef (
    .clk   (clk),
    .we    (cload),
    .waddr ({~bank_q, caddr}),
    .wdata (cin),
    .raddr ({bank_q, k_q}),
    .rdata (c_raw)
  );

  assign dout    = dout_q;
  assign dout_ch = dout_ch_q;
  assign valid   = valid_q;
  assign sat     = sat_q;
  assign err     = err_q;

endmodule

// File: tb/tb_w4823_fir_mc.sv
// tb/tb_w4823_fir_mc.sv - directed self-checking bench for w4823_fir_mc (NTAP=8; NCH=2/SHIFT=0 and NCH=3/SHIFT=1)
module tb_w4823_fir_mc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] din;
  logic [1:0]  tch;
  logic        vin0, vin1;
  logic [16:0] cin;
  logic [2:0]  caddr;
  logic        cload, cswap;

  logic        ready0, valid0, sat0, err0, dch0;
  logic [15:0] dout0;
  logic        ready1, valid1, sat1, err1;
  logic [1:0]  dch1;
  logic [15:0] dout1;

  int checks = 0;
  int errors = 0;

  w4823_fir_mc #(.DW(16), .CW(17), .NTAP(8), .NCH(2), .SHIFT(0)) u0 (
    .clk(clk), .rst(rst), .din(din), .din_ch(tch[0]), .valid_in(vin0), .ready(ready0),
    .cin(cin), .caddr(caddr), .cload(cload), .cswap(cswap),
    .dout(dout0), .dout_ch(dch0), .valid(valid0), .sat(sat0), .err(err0)
  );

  w4823_fir_mc #(.DW(16), .CW(17), .NTAP(8), .NCH(3), .SHIFT(1)) u1 (
    .clk(clk), .rst(rst), .din(din), .din_ch(tch), .valid_in(vin1), .ready(ready1),
    .cin(cin), .caddr(caddr), .cload(cload), .cswap(cswap),
    .dout(dout1), .dout_ch(dch1), .valid(valid1), .sat(sat1), .err(err1)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int k, input int c);
    @(negedge clk);
    cload = 1'b1;
    caddr = k[2:0];
    cin   = c[16:0];
    @(negedge clk);
    cload = 1'b0;
  endtask

  task automatic pulse_swap();
    @(negedge clk);
    cswap = 1'b1;
    @(negedge clk);
    cswap = 1'b0;
  endtask

  task automatic send(input int inst, input int ch, input int d, input bit swp,
                      input int exp_d, input bit exp_sat, input string tag);
    int n;
    @(negedge clk);
    din   = d[15:0];
    tch   = ch[1:0];
    cswap = swp;
    if (inst == 0) vin0 = 1'b1;
    else           vin1 = 1'b1;
    @(negedge clk);
    vin0  = 1'b0;
    vin1  = 1'b0;
    cswap = 1'b0;
    chk({tag, "_busy"}, (inst == 0) ? ready0 : ready1, 0);
    n = 1;
    while ((((inst == 0) ? valid0 : valid1) !== 1'b1) && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, 11);
    chk({tag, "_dout"}, (inst == 0) ? $signed(dout0) : $signed(dout1), exp_d);
    chk({tag, "_ch"}, (inst == 0) ? {1'b0, dch0} : dch1, ch);
    chk({tag, "_sat"}, (inst == 0) ? sat0 : sat1, exp_sat);
    @(negedge clk);
    chk({tag, "_rdy"}, (inst == 0) ? ready0 : ready1, 1);
    chk({tag, "_vlo"}, (inst == 0) ? valid0 : valid1, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    rst = 1'b1; din = '0; tch = '0; vin0 = 1'b0; vin1 = 1'b0;
    cin = '0; caddr = '0; cload = 1'b0; cswap = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready0", ready0, 1);
    chk("rst_valid0", valid0, 0);
    chk("rst_dout0", $signed(dout0), 0);
    chk("rst_dch0", dch0, 0);
    chk("rst_sat0", sat0, 0);
    chk("rst_err0", err0, 0);
    chk("rst_ready1", ready1, 1);
    chk("rst_dout1", $signed(dout1), 0);

    // Impulse on ch0 interleaved with constant 100 on ch1, coefficients 1..8.
    for (int k = 0; k < 8; k++) load(k, k + 1);
    pulse_swap();
    for (int i = 0; i < 8; i++) begin
      send(0, 0, (i == 0) ? 1 : 0, 1'b0, i + 1, 1'b0, "imp");
      send(0, 1, 100, 1'b0, 100 * (i + 1) * (i + 2) / 2, 1'b0, "iso");
    end
    send(0, 1, 100, 1'b0, 3600, 1'b0, "iso_steady");

    // Shadow loaded with 2s: old bank stays in use until a swap lands on an accept.
    for (int k = 0; k < 8; k++) load(k, 2);
    send(0, 1, 100, 1'b0, 3600, 1'b0, "old_bank");
    send(0, 0, 5, 1'b1, 10, 1'b0, "swap");

    // Saturation: positive full-scale, then negative full-scale.
    for (int k = 0; k < 8; k++) load(k, 17'h0FFFF);
    pulse_swap();
    for (int i = 0; i < 8; i++) send(0, 0, 16'h7FFF, 1'b0, 32767, 1'b1, "sat_pos");
    for (int i = 0; i < 8; i++) send(0, 0, 16'h8000, 1'b0, (i < 3) ? 32767 : -32768, 1'b1, "sat_neg");

    // Reset in cycle t0+4 of a computation.
    @(negedge clk);
    din = 16'h1234; tch = 2'd0; vin0 = 1'b1;
    @(negedge clk);
    vin0 = 1'b0;
    vcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (valid0 === 1'b1) vcnt++;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (valid0 === 1'b1) vcnt++;
    end
    chk("rst_mid_novalid", vcnt, 0);
    chk("rst_mid_ready", ready0, 1);

    for (int k = 0; k < 8; k++) load(k, (k == 0) ? 1 : 0);
    pulse_swap();
    send(0, 0, 1, 1'b0, 1, 1'b0, "rst_fill");

    // SHIFT=1 rounding, half up: 3/2 -> 2, -3/2 -> -1.
    send(1, 0, 3, 1'b0, 2, 1'b0, "shift1_pos");
    send(1, 1, -3, 1'b0, -1, 1'b0, "shift1_neg");

    // Illegal channel on the 3-channel instance.
    @(negedge clk);
    din = 16'd7; tch = 2'd3; vin1 = 1'b1;
    chk("ill_ready_offer", ready1, 1);
    @(negedge clk);
    vin1 = 1'b0;
    chk("ill_err_hi", err1, 1);
    chk("ill_ready_after", ready1, 1);
    @(negedge clk);
    chk("ill_err_lo", err1, 0);
    vcnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (valid1 === 1'b1) vcnt++;
    end
    chk("ill_novalid", vcnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
